// File: rtl/pi_code_ctrl.sv
// pi_code_ctrl: digital CDR loop filter that drives the phase-interpolator code.
//
// Bang-bang phase-detector votes are summed over DECIM valid samples. The sign of
// that sum feeds a proportional + integral update of the phase code one clock later.
// A two-state lock FSM (ACQ/TRACK) selects the proportional gain and drives locked_o.
//
// Ports:
//   clk          loop clock
//   rst_n        asynchronous active-low reset
//   pd_valid_i   pd_up_i/pd_dn_i qualify this cycle
//   pd_up_i      data late: advance phase
//   pd_dn_i      data early: retard phase
//   freeze_i     hold the loop (an already-registered decision still completes)
//   code_o       registered PI code; [CODE_W-1:8] octant, [7:0] weight at defaults
//   code_upd_o   one-cycle pulse coincident with each new code value
//   locked_o     lock indicator; high exactly while the FSM is in TRACK
//
// Optional build macro PI_CODE_OVERRIDE_EN adds:
//   ovr_en_i     load ovr_code_i every edge and restart the loop from ACQ
//   ovr_code_i   override code value
//
// Handshake: pd_* are sampled on every rising edge where pd_valid_i=1 and
// freeze_i=0; there is no backpressure. code_upd_o is a single-cycle strobe and
// code_o is stable between strobes.
module pi_code_ctrl #(
  parameter int CODE_W     = 11,
  parameter int DECIM      = 8,
  parameter int KP         = 4,
  parameter int KI_SHIFT   = 6,
  parameter int FREQ_W     = 16,
  parameter int INIT_CODE  = 0,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pd_valid_i,
  input  logic              pd_up_i,
  input  logic              pd_dn_i,
  input  logic              freeze_i,
`ifdef PI_CODE_OVERRIDE_EN
  input  logic              ovr_en_i,
  input  logic [CODE_W-1:0] ovr_code_i,
`endif
  output logic [CODE_W-1:0] code_o,
  output logic              code_upd_o,
  output logic              locked_o
);

  localparam int CNT_W  = $clog2(DECIM);
  // Vote sum must hold +/-DECIM once the final sample is included.
  localparam int VS_W   = $clog2(DECIM) + 2;
  localparam int ST_W   = $clog2(LOCK_CNT + 1);
  localparam int RUN_W  = $clog2(UNLOCK_RUN + 1);
  localparam int STEP_W = FREQ_W + 2;
  localparam int FMAX_I = (1 << (FREQ_W - 1)) - 1;

  localparam logic [0:0] ST_ACQ   = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  // Two-bit signed sign encoding: +1, -1, 0.
  localparam logic [1:0] SGN_POS  = 2'b01;
  localparam logic [1:0] SGN_NEG  = 2'b11;
  localparam logic [1:0] SGN_ZERO = 2'b00;

  localparam logic signed [VS_W-1:0]   VOTE_P1 = VS_W'(1);
  localparam logic signed [VS_W-1:0]   VOTE_M1 = -VOTE_P1;
  localparam logic signed [FREQ_W:0]   SUM_MAX = (FREQ_W+1)'(FMAX_I);
  localparam logic signed [FREQ_W:0]   SUM_MIN = -SUM_MAX;
  localparam logic signed [STEP_W-1:0] KP_TRK  = STEP_W'(KP);
  localparam logic signed [STEP_W-1:0] KP_ACQ  = STEP_W'(2 * KP);
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [ST_W-1:0]          ST_MAX   = {ST_W{1'b1}};
  localparam logic [RUN_W-1:0]         RUN_MAX  = {RUN_W{1'b1}};

  logic [CODE_W-1:0]        code_q, code_d;
  logic                     code_upd_q, code_upd_d;
  logic [0:0]               state_q, state_d;
  logic signed [FREQ_W-1:0] freq_acc_q, freq_acc_d;
  logic signed [VS_W-1:0]   vote_sum_q, vote_sum_d;
  logic [CNT_W-1:0]         sample_cnt_q, sample_cnt_d;
  logic                     dec_pend_q, dec_pend_d;
  logic [1:0]               dec_sign_q, dec_sign_d;
  logic [1:0]               prev_sign_q, prev_sign_d;
  logic [RUN_W-1:0]         run_q, run_d;
  logic [ST_W-1:0]          stable_q, stable_d;

  // Datapath intermediates.
  logic                     sample_en;
  logic signed [VS_W-1:0]   vote, vote_sum_inc;
  logic [1:0]               sign_new;
  logic signed [FREQ_W:0]   freq_sum;
  logic signed [FREQ_W-1:0] freq_new, integ;
  logic signed [STEP_W-1:0] prop, step;
  logic [CODE_W-1:0]        code_next;
  logic                     sign_nz, same_sign;
  logic [RUN_W-1:0]         run_upd;
  logic [ST_W-1:0]          stable_upd;
  logic [0:0]               state_upd;

  assign sample_en = pd_valid_i & ~freeze_i;

  // Vote and decimation arithmetic.
  always_comb begin
    vote = '0;
    if (pd_up_i & ~pd_dn_i) vote = VOTE_P1;
    else if (pd_dn_i & ~pd_up_i) vote = VOTE_M1;
    vote_sum_inc = vote_sum_q + vote;
    if (vote_sum_inc == '0)          sign_new = SGN_ZERO;
    else if (vote_sum_inc[VS_W-1])   sign_new = SGN_NEG;
    else                             sign_new = SGN_POS;
  end

  // Loop update arithmetic, driven by the registered decision.
  always_comb begin
    freq_sum = $signed({freq_acc_q[FREQ_W-1], freq_acc_q}) +
               $signed({{(FREQ_W-1){dec_sign_q[1]}}, dec_sign_q});
    if (freq_sum > SUM_MAX)      freq_new = SUM_MAX[FREQ_W-1:0];
    else if (freq_sum < SUM_MIN) freq_new = SUM_MIN[FREQ_W-1:0];
    else                         freq_new = freq_sum[FREQ_W-1:0];

    integ = freq_new >>> KI_SHIFT;

    prop = '0;
    case (dec_sign_q)
      SGN_POS: prop = (state_q == ST_TRACK) ? KP_TRK : KP_ACQ;
      SGN_NEG: prop = (state_q == ST_TRACK) ? -KP_TRK : -KP_ACQ;
      default: prop = '0;
    endcase

    step      = prop + $signed({{2{integ[FREQ_W-1]}}, integ});
    // Modular add: truncating the signed step wraps the code naturally.
    code_next = code_q + step[CODE_W-1:0];
  end

  // Lock bookkeeping evaluated against the pending decision.
  always_comb begin
    sign_nz   = (dec_sign_q != SGN_ZERO);
    same_sign = sign_nz && (dec_sign_q == prev_sign_q);
    if (same_sign) begin
      run_upd    = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      stable_upd = '0;
    end else begin
      run_upd    = sign_nz ? RUN_W'(1) : '0;
      stable_upd = (stable_q == ST_MAX) ? stable_q : stable_q + 1'b1;
    end
    state_upd = state_q;
    if (state_q == ST_ACQ) begin
      if (stable_upd >= ST_W'(LOCK_CNT)) state_upd = ST_TRACK;
    end else if (run_upd >= RUN_W'(UNLOCK_RUN)) begin
      state_upd  = ST_ACQ;
      stable_upd = '0;
    end
  end

  // Next-state selection.
  always_comb begin
    code_d       = code_q;
    code_upd_d   = 1'b0;
    state_d      = state_q;
    freq_acc_d   = freq_acc_q;
    vote_sum_d   = vote_sum_q;
    sample_cnt_d = sample_cnt_q;
    dec_pend_d   = 1'b0;
    dec_sign_d   = dec_sign_q;
    prev_sign_d  = prev_sign_q;
    run_d        = run_q;
    stable_d     = stable_q;

    if (sample_en) begin
      if (sample_cnt_q == CNT_LAST) begin
        vote_sum_d   = '0;
        sample_cnt_d = '0;
        dec_sign_d   = sign_new;
        dec_pend_d   = 1'b1;
      end else begin
        vote_sum_d   = vote_sum_inc;
        sample_cnt_d = sample_cnt_q + 1'b1;
      end
    end

    // A registered decision completes even while frozen.
    if (dec_pend_q) begin
      freq_acc_d = freq_new;
      code_d     = code_next;
      code_upd_d = 1'b1;
      run_d      = run_upd;
      stable_d   = stable_upd;
      state_d    = state_upd;
      if (sign_nz) prev_sign_d = dec_sign_q;
    end

`ifdef PI_CODE_OVERRIDE_EN
    if (ovr_en_i) begin
      code_d       = ovr_code_i;
      code_upd_d   = 1'b1;
      freq_acc_d   = '0;
      vote_sum_d   = '0;
      sample_cnt_d = '0;
      dec_pend_d   = 1'b0;
      stable_d     = '0;
      run_d        = '0;
      state_d      = ST_ACQ;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q       <= CODE_W'(INIT_CODE);
      code_upd_q   <= 1'b0;
      state_q      <= ST_ACQ;
      freq_acc_q   <= '0;
      vote_sum_q   <= '0;
      sample_cnt_q <= '0;
      dec_pend_q   <= 1'b0;
      dec_sign_q   <= SGN_ZERO;
      prev_sign_q  <= SGN_ZERO;
      run_q        <= '0;
      stable_q     <= '0;
    end else begin
      code_q       <= code_d;
      code_upd_q   <= code_upd_d;
      state_q      <= state_d;
      freq_acc_q   <= freq_acc_d;
      vote_sum_q   <= vote_sum_d;
      sample_cnt_q <= sample_cnt_d;
      dec_pend_q   <= dec_pend_d;
      dec_sign_q   <= dec_sign_d;
      prev_sign_q  <= prev_sign_d;
      run_q        <= run_d;
      stable_q     <= stable_d;
    end
  end

  assign code_o     = code_q;
  assign code_upd_o = code_upd_q;
  // locked is the FSM state itself.
  assign locked_o   = (state_q == ST_TRACK);

endmodule

// File: tb/tb_pi_code_ctrl.sv
// Testbench for pi_code_ctrl: vector table, hand-written corner sequences,
// randomized stimulus against a reference model, and a narrow-integrator
// instance for saturation.
module tb_pi_code_ctrl;

  localparam int DECIM = 8;
  localparam int FMAX  = 32767;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        pd_valid = 1'b0, pd_up = 1'b0, pd_dn = 1'b0, freeze = 1'b0;
  logic [10:0] code;
  logic        code_upd, locked;

  logic        s_valid = 1'b0, s_up = 1'b0;
  logic [10:0] s_code;
  logic        s_upd, s_locked;

  pi_code_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pd_valid_i (pd_valid),
    .pd_up_i    (pd_up),
    .pd_dn_i    (pd_dn),
    .freeze_i   (freeze),
`ifdef PI_CODE_OVERRIDE_EN
    .ovr_en_i   (1'b0),
    .ovr_code_i (11'd0),
`endif
    .code_o     (code),
    .code_upd_o (code_upd),
    .locked_o   (locked)
  );

  // Narrow integrator (saturates at +/-511) so saturation is reachable quickly.
  pi_code_ctrl #(.FREQ_W(10)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .pd_valid_i (s_valid),
    .pd_up_i    (s_up),
    .pd_dn_i    (1'b0),
    .freeze_i   (1'b0),
`ifdef PI_CODE_OVERRIDE_EN
    .ovr_en_i   (1'b0),
    .ovr_code_i (11'd0),
`endif
    .code_o     (s_code),
    .code_upd_o (s_upd),
    .locked_o   (s_locked)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_code, m_freq, m_prev, m_run, m_stable, m_psign;
  bit m_track, m_pending, m_upd;
  int m_votes[$];

  task automatic model_reset();
    m_code = 0; m_freq = 0; m_prev = 0; m_run = 0; m_stable = 0;
    m_psign = 0; m_track = 0; m_pending = 0; m_upd = 0;
    m_votes.delete();
  endtask

  task automatic model_update(input int sign);
    int step;
    m_freq = m_freq + sign;
    if (m_freq > FMAX) m_freq = FMAX;
    if (m_freq < -FMAX) m_freq = -FMAX;
    step = sign * (m_track ? 4 : 8) + (m_freq >>> 6);
    m_code = (m_code + step) & 2047;
    if (sign == 0 || sign != m_prev) begin
      if (m_stable < 127) m_stable++;
      m_run = (sign != 0) ? 1 : 0;
    end else begin
      m_run++;
      m_stable = 0;
    end
    if (sign != 0) m_prev = sign;
    if (!m_track && m_stable >= 64) m_track = 1;
    else if (m_track && m_run >= 4) begin
      m_track = 0;
      m_stable = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit u, input bit d, input bit f);
    int s;
    m_upd = 0;
    if (m_pending) begin
      model_update(m_psign);
      m_upd = 1;
      m_pending = 0;
    end
    if (v && !f) begin
      m_votes.push_back((u && !d) ? 1 : ((d && !u) ? -1 : 0));
      if (m_votes.size() == DECIM) begin
        s = m_votes.sum();
        m_psign = (s > 0) ? 1 : ((s < 0) ? -1 : 0);
        m_pending = 1;
        m_votes.delete();
      end
    end
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic tick(input bit v, input bit u, input bit d, input bit f);
    pd_valid = v; pd_up = u; pd_dn = d; freeze = f;
    model_step(v, u, d, f);
    @(posedge clk);
    @(negedge clk);
    check("code", code, m_code);
    check("code_upd", code_upd, m_upd);
    check("locked", locked, m_track);
  endtask

  task automatic blk(input int nu, input int nd, input int nt);
    for (int i = 0; i < nu; i++) tick(1, 1, 0, 0);
    for (int i = 0; i < nd; i++) tick(1, 0, 1, 0);
    for (int i = 0; i < nt; i++) tick(1, 1, 1, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pd_valid = 0; pd_up = 0; pd_dn = 0; freeze = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    pd_valid = 0; pd_up = 0; pd_dn = 0; freeze = 0;
    #1;
    check({tag, "_code"}, code, 0);
    check({tag, "_upd"}, code_upd, 0);
    check({tag, "_locked"}, locked, 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      check({tag, "_post_code"}, code, 0);
      check({tag, "_post_upd"}, code_upd, 0);
    end
  endtask

  task automatic alt_blocks(input int n, input bit start_up);
    for (int b = 0; b < n; b++) begin
      if ((b % 2 == 0) == start_up) blk(8, 0, 0);
      else blk(0, 8, 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n_up;
    int n_dn;
    int n_tie;
    int exp_code;
    bit exp_locked;
  } vec_t;

  vec_t tbl[10];

  // ---------------- main test ----------------
  initial begin
    int c0, c1, bias;
    bit v, u, d, f;

    // Blocks applied back to back from reset; each is followed by one idle
    // clock on which the update lands. Gain is 8 (ACQ) throughout.
    tbl[0] = '{8, 0, 0, 8,    0};  // freq 1, step +8
    tbl[1] = '{0, 8, 0, 0,    0};  // freq 0, step -8
    tbl[2] = '{0, 8, 0, 2039, 0};  // freq -1, step -9 (wrap below 0)
    tbl[3] = '{0, 0, 8, 2038, 0};  // tie: step = -1>>>6 = -1
    tbl[4] = '{5, 3, 0, 2046, 0};  // +, freq 0, step +8
    tbl[5] = '{3, 5, 0, 2037, 0};  // -, freq -1, step -9
    tbl[6] = '{4, 4, 0, 2036, 0};  // balanced: step -1
    tbl[7] = '{2, 2, 4, 2035, 0};  // balanced with ties: step -1
    tbl[8] = '{8, 0, 0, 2043, 0};  // +, freq 0, step +8
    tbl[9] = '{8, 0, 0, 3,    0};  // +, freq 1, step +8 (wrap 2047->0)

    model_reset();
    repeat (2) @(negedge clk);
    check("reset_code", code, 0);
    check("reset_upd", code_upd, 0);
    check("reset_locked", locked, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      blk(tbl[i].n_up, tbl[i].n_dn, tbl[i].n_tie);
      tick(0, 0, 0, 0);
      check($sformatf("tbl%0d_code", i), code, tbl[i].exp_code);
      check($sformatf("tbl%0d_upd", i), code_upd, 1);
      check($sformatf("tbl%0d_locked", i), locked, tbl[i].exp_locked);
    end

    // Asynchronous reset while code_upd is high and code is nonzero.
    async_reset_check("areset");

    // Advance: code appears exactly one clock after the 8th sample.
    for (int i = 0; i < 8; i++) tick(1, 1, 0, 0);
    check("adv_latency_code", code, 0);
    check("adv_latency_upd", code_upd, 0);
    tick(0, 0, 0, 0);
    check("adv_code", code, 8);
    check("adv_upd", code_upd, 1);
    tick(0, 0, 0, 0);
    check("adv_upd_single", code_upd, 0);

    // Wrap from reset.
    do_reset();
    blk(0, 8, 0);
    tick(0, 0, 0, 0);
    check("wrap_code", code, 2039);
    check("wrap_upd", code_upd, 1);

    // Tie block then freeze in the middle of a block.
    do_reset();
    blk(0, 0, 8);
    tick(0, 0, 0, 0);
    check("tie_code", code, 0);
    check("tie_upd", code_upd, 1);
    blk(4, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 0, 1);
      check("frz_no_upd", code_upd, 0);
    end
    blk(3, 0, 0);
    check("frz_not_yet", code, 0);
    tick(1, 1, 0, 0);
    tick(0, 0, 0, 0);
    check("frz_code", code, 8);
    check("frz_upd", code_upd, 1);
    // Decision registered just before freeze still completes.
    blk(8, 0, 0);
    tick(1, 1, 0, 1);
    check("frz_pending_code", code, 16);
    check("frz_pending_upd", code_upd, 1);

    // Reset mid-block discards the partial votes.
    do_reset();
    blk(5, 0, 0);
    do_reset();
    blk(7, 0, 0);
    tick(1, 1, 0, 0);
    check("midrst_wait", code_upd, 0);
    tick(0, 0, 0, 0);
    check("midrst_code", code, 8);

    // Lock: 64 alternating blocks; lock on the 64th update.
    do_reset();
    alt_blocks(63, 1);
    tick(0, 0, 0, 0);
    check("lock_63", locked, 0);
    blk(0, 8, 0);
    tick(0, 0, 0, 0);
    check("lock_64", locked, 1);
    check("lock_64_upd", code_upd, 1);
    // Four same-sign updates drop lock; TRACK gain 4 on the 4th, ACQ 8 after.
    for (int k = 0; k < 4; k++) begin
      c0 = code;
      blk(8, 0, 0);
      tick(0, 0, 0, 0);
      check($sformatf("unlock_%0d", k + 1), locked, (k < 3) ? 1 : 0);
    end
    c1 = code;
    check("unlock_step_track", (c1 - c0) & 2047, 4);
    blk(8, 0, 0);
    tick(0, 0, 0, 0);
    check("unlock_step_acq", (code - c1) & 2047, 8);
    // Relock, then reset asynchronously while locked.
    alt_blocks(64, 0);
    tick(0, 0, 0, 0);
    check("relock", locked, 1);
    async_reset_check("areset_locked");

    // Randomized stimulus with drifting up/down bias.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = $urandom_range(0, 100);
      v = ($urandom_range(0, 99) < 75);
      u = ($urandom_range(0, 99) < bias);
      d = ($urandom_range(0, 99) < (100 - bias));
      f = ($urandom_range(0, 99) < 8);
      tick(v, u, d, f);
    end

    // Saturation on the narrow instance: integrator stops at 511, step 8+7.
    do_reset();
    begin
      int mc, mf;
      mc = 0;
      for (int k = 1; k <= 530; k++) begin
        mf = (k > 511) ? 511 : k;
        mc = (mc + 8 + (mf >>> 6)) & 2047;
        exp_q.push_back(11'(mc));
      end
    end
    s_valid = 1'b1;
    s_up = 1'b1;
    for (int n = 0; n < 4400 && exp_q.size() > 0; n++) begin
      tick(0, 0, 0, 0);
      if (s_upd) begin
        c0 = s_code;
        check("sat_code", c0, int'(exp_q.pop_front()));
        if (exp_q.size() == 0) begin
          tick(0, 0, 0, 0);
          check("sat_upd_single", s_upd, 0);
        end
      end
    end
    check("sat_drained", exp_q.size(), 0);
    check("sat_locked", s_locked, 0);
    s_valid = 1'b0;
    s_up = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
